// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one fixed-latency pipelined multiplier among
// NUM_REQ requesters; a tag pipeline routes each product back to its owner.
module mul_rr_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int IDW         = 2
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_I0,
  input  logic [8*NUM_REQ-1:0] req_I1,
  output logic [7:0]           mul_I0,
  output logic [7:0]           mul_I1,
  input  logic [7:0]           mul_O,
  output logic [NUM_REQ-1:0]   res_valid,
  output logic [7:0]           res_O,
  output logic [2:0]           in_flight
);

  // Handshake: a request transfers at a rising edge when req_valid[i] and
  // req_ready[i] are both high; req_ready is one-hot or zero and never rises
  // without req_valid. The multiplier has no handshake and never stalls.

  logic [IDW-1:0]         rr_ptr_q, rr_ptr_d;
  logic                   grant_found;
  logic [IDW-1:0]         grant_id;
  logic [MUL_LATENCY-1:0] tag_v_q, tag_v_d;
  logic [IDW-1:0]         tag_id_q [MUL_LATENCY];
  logic [IDW-1:0]         tag_id_d [MUL_LATENCY];
  logic [2:0]             in_flight_q, in_flight_d;

  // Search starts just after the last winner and wraps around.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!grant_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        grant_found = 1'b1;
        grant_id    = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_found) req_ready[grant_id] = 1'b1;
  end

  assign mul_I0 = grant_found ? req_I0[8*grant_id +: 8] : 8'd0;
  assign mul_I1 = grant_found ? req_I1[8*grant_id +: 8] : 8'd0;

  always_comb begin
    rr_ptr_d    = grant_found ? grant_id : rr_ptr_q;
    tag_v_d     = '0;
    tag_v_d[0]  = grant_found;
    tag_id_d[0] = grant_id;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
    // Accept and retire in the same cycle cancel out.
    in_flight_d = in_flight_q + {2'b00, grant_found} - {2'b00, tag_v_q[MUL_LATENCY-1]};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      rr_ptr_q    <= IDW'(NUM_REQ - 1);
      tag_v_q     <= '0;
      in_flight_q <= '0;
      for (int k = 0; k < MUL_LATENCY; k++) tag_id_q[k] <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      tag_v_q     <= tag_v_d;
      in_flight_q <= in_flight_d;
      for (int k = 0; k < MUL_LATENCY; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end

  always_comb begin
    res_valid = '0;
    if (tag_v_q[MUL_LATENCY-1]) res_valid[tag_id_q[MUL_LATENCY-1]] = 1'b1;
  end

  assign res_O     = mul_O;
  assign in_flight = in_flight_q;

endmodule

// File: doc/mul_rr_scheduler.md
Name: mul_rr_scheduler

Overview:
- Shares one pipelined 8-bit multiplier (fixed 3-cycle latency, no stall, no handshake) among NUM_REQ requesters.
- Grants one request per cycle using round-robin arbitration.
- Tracks each issued operation's owner through a tag pipeline matched to the multiplier latency, and returns the product to that owner only.
- Sits between the requesting datapath lanes and a single multiplier instance, uint8 or int8; signedness is irrelevant to the scheduler.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MUL_LATENCY, 3, clock edges from operands at the multiplier inputs to the product at mul_O.
- IDW, 2, requester-id width; must equal ceil(log2(NUM_REQ)).

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_I0  in  8*NUM_REQ  operand A, requester i at bits [8i+7:8i].
- req_I1  in  8*NUM_REQ  operand B, same packing.
- mul_I0  out  8  to multiplier I0.
- mul_I1  out  8  to multiplier I1.
- mul_O  in  8  from multiplier O.
- res_valid  out  NUM_REQ  one-hot result strobe to the owning requester.
- res_O  out  8  product, broadcast; qualified by res_valid.
- in_flight  out  3  count of issued, not-yet-returned operations (0..MUL_LATENCY).

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (reset_n low at a rising edge):
  - rr_ptr <= NUM_REQ-1, so requester 0 has top priority first.
  - All tag-pipeline valid bits <= 0 and in_flight <= 0.
  - Outputs are then res_valid=0, req_ready=0 (unless a requester is valid after reset), mul_I0/mul_I1=0 when no grant.
- Arbitration (combinational within the cycle):
  - Search req_valid starting at (rr_ptr+1) mod NUM_REQ and wrapping; the first valid index g gets req_ready[g]=1.
  - req_ready is never asserted for a requester whose req_valid is low.
  - If there is no valid request, req_ready=0.
- Issue: in the grant cycle, mul_I0/mul_I1 = req_I0/req_I1 slice g. With no grant they are driven to 0. The multiplier captures them at the cycle's rising edge.
- Handshake and pointer update: a transfer occurs when req_valid[g] & req_ready[g] are both high at the edge. At that edge rr_ptr <= g. With no transfer, rr_ptr holds.
- Throughput: one accept per cycle total, no bubbles. The multiplier never stalls, so there is no backpressure beyond arbitration.
- Tag pipeline: MUL_LATENCY stages of {valid, id}.
  - Stage 0 loads {transfer, g} each edge; stage k loads stage k-1.
  - Last stage drives res_valid = onehot(id) when valid, else 0.
  - res_O = mul_O every cycle.
- Latency: an operation accepted in cycle t gives res_valid[owner]=1 in cycle t+MUL_LATENCY, and res_O there holds the low 8 bits of the product (wrap, no saturation).
- in_flight: number of valid tag stages. Each edge it increments on accept, decrements on retire, or does both in the same cycle (net unchanged).
- Requester holding valid:
  - Requester gets one grant per round. Its operand slice may change after each accepted transfer.
  - Dropping req_valid before a grant is legal; nothing is issued.
- Single requester continuously valid: it is granted every cycle.
- All requesters continuously valid: grant order is 0,1,2,3,0,… and each requester gets exactly 1/NUM_REQ of the slots.
- Reset mid-operation:
  - In-flight tags are cleared, and products still emerging from the multiplier are discarded (res_valid stays 0).
  - First grant after reset goes to the lowest-index valid requester.
- Simultaneous retire and accept for the same requester is legal; both strobes occur independently.

Test Plan:
- Reset, then req_valid=4'b0001, operands 3 and 5 in cycle 1 -> req_ready=0001 in cycle 1; res_valid=0001 with res_O=15 in cycle 4; in_flight goes 1,1,1 then 0.
- req_valid=1111 held for 8 cycles with operand values equal to requester index+2 -> grants in order 0,1,2,3,0,1,2,3. Results returned 3 cycles later, in the same order, with products 4,9,16,25.
- Overflow: 16*17 issued -> res_O=0x10 (272 mod 256); -1*-1 as int8 (0xFF*0xFF) -> res_O=0x01.
- Pointer: req 2 granted; next cycle req_valid=0101 -> req 0 granted (wrap from 2 skips invalid 3). Next cycle req_valid=0101 -> req 2 granted.
- Reset_n pulsed low one cycle while 3 operations are in flight -> no res_valid in the following 3 cycles, in_flight=0 after reset, and the next grant is to the lowest-index valid requester.
- Idle: req_valid=0 for 5 cycles -> req_ready=0, mul_I0=mul_I1=0, res_valid=0 throughout, and rr_ptr unchanged (verified by the next grant order).
